nand8_test_sequencer: RTL and testbench
=======================================

# nand8_test_sequencer

Self-checking stimulus controller for the 8-input NAND gate model in the 74LSXX library. On `start` it drives all 256 input patterns onto the gate under test, and waits a programmable settle time so the gate's propagation DELAY can elapse. It then samples the gate output, compares it against the ideal NAND result, and accumulates a pass/fail summary. It sits between a lab top level (buttons/LEDs) or a testbench and one `one_8_input_nand` instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles the pattern is held before sampling. Minimum 1. Must satisfy SETTLE_CYCLES × Tclk > gate DELAY.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE or DONE to begin a sweep.
- `dut_in`  out  8  pattern to the gate inputs a..h; bit 7 = a, bit 0 = h.
- `dut_y`  in  1  gate output, same clock domain.
- `busy`  out  1  high from the first SETTLE cycle through the last SAMPLE cycle.
- `done`  out  1  high while in DONE.
- `pass`  out  1  `done` && `err_count` == 0.
- `err_count`  out  9  mismatch count, 0..256, saturating.
- `first_fail`  out  8  pattern of the first mismatch; valid when `first_fail_valid` is high.
- `first_fail_valid`  out  1  set on the first mismatch of a sweep.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, `start`=1 → SETTLE:
  - `dut_in`=8'h00, settle counter=SETTLE_CYCLES−1.
  - `err_count`, `first_fail`, `first_fail_valid` cleared.
- SETTLE: counter decrements each cycle. At counter=0 the next state is SAMPLE.
- SAMPLE:
  - expected = ~&`dut_in`. A mismatch occurs when `dut_y` ≠ expected.
  - On mismatch: `err_count` increments, saturating at 256. If `first_fail_valid` is 0, capture `first_fail`=`dut_in` and set `first_fail_valid`.
  - If `dut_in`==8'hFF → DONE. Otherwise increment `dut_in`, reload the counter → SETTLE.
- DONE: results hold and `dut_in` holds 8'hFF. `start`=1 restarts exactly as from IDLE.
- `start` is ignored in SETTLE and SAMPLE.
- `dut_in` never wraps. The 8'hFF check precedes the increment.
- `reset` overrides everything, including mid-sweep:
  - next state IDLE.
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_fail_valid`=0.

## Timing
- Each pattern occupies SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in SETTLE plus one in SAMPLE.
- Full sweep latency: `start` sampled at edge 0 → `done` high after edge 256×(SETTLE_CYCLES+1).
- `dut_y` is sampled at the rising edge that ends the SAMPLE cycle. A pattern has therefore been stable for SETTLE_CYCLES+1 full cycles when sampled.
- All outputs are registered. `pass` is derived combinationally from registered `done` and `err_count`.
- A mismatch in the final SAMPLE cycle is reflected in `err_count` in the same edge that raises `done`.

## Configuration
- `NAND8_SEQ_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch in SAMPLE moves the block to DONE immediately. `err_count`=1, `first_fail` is the failing pattern, `dut_in` holds that pattern.
  - Undefined: the full 256-pattern sweep always runs and `err_count` reports the total.

## Structure
- Package `nand8_seq_pkg` holds:
  - state enum `nand8_seq_state_t` (IDLE, SETTLE, SAMPLE, DONE).
  - constants `PAT_W`=8, `LAST_PAT`=8'hFF, `ERR_W`=9.
  - function `nand8_expected(pattern)` returning ~&pattern, which is shared with the bench scoreboard.
- Sub-module `nand8_settle_timer`: loadable down-counter with a `load` strobe, a `zero` flag, and `clk`/`reset`, parameterised by SETTLE_CYCLES.

## Test plan
- Fault-free gate, DELAY=10 ns, 100 MHz clk, SETTLE_CYCLES=4, pulse `start` → `done`=1 after 1280 cycles; `pass`=1; `err_count`=0; `first_fail_valid`=0.
- Output stuck-at-1 → `err_count`=1, `first_fail`=8'hFF, `pass`=0.
- Output stuck-at-0 → `err_count`=255, `first_fail`=8'h00. With `NAND8_SEQ_STOP_ON_FAIL_EN` defined: `done` after 5 cycles, `err_count`=1, `dut_in`=8'h00.
- Input `c` stuck-at-0 inside the gate → first mismatch at `first_fail`=8'hFF, `err_count`=1.
- Assert `reset` at cycle 600 of a sweep → next cycle all outputs zero and state IDLE. A new `start` runs a complete 1280-cycle sweep.
- Hold `start`=1 throughout the sweep → the sweep is not restarted. Once `done`, the next edge restarts it, and the counters clear.

Source files
------------

// File: rtl/nand8_test_sequencer_pkg.sv
// Shared types, widths and the ideal NAND reference for the 8-input NAND sweep sequencer.
package nand8_seq_pkg;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned ERR_W = 9;
    localparam logic [PAT_W-1:0] LAST_PAT = 8'hFF;
    localparam logic [ERR_W-1:0] ERR_MAX  = 9'd256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } nand8_seq_state_t;

    // Ideal gate response for a pattern (bit 7 = input a).
    function automatic logic nand8_expected(input logic [PAT_W-1:0] pattern);
        return ~&pattern;
    endfunction

endpackage

// File: rtl/nand8_test_sequencer_if.sv
// Control/result bus between a lab top level (or bench) and the NAND sweep sequencer.
interface nand8_test_sequencer_if;
    import nand8_seq_pkg::*;

    logic                 start;
    logic                 dut_y;
    logic [PAT_W-1:0]     dut_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic [PAT_W-1:0]     first_fail;
    logic                 first_fail_valid;

    // Lab top / bench side: requests sweeps, returns gate output.
    modport master (
        output start,
        output dut_y,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail,
        input  first_fail_valid
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  dut_y,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail,
        output first_fail_valid
    );
endinterface

// File: rtl/nand8_test_sequencer_settle_timer.sv
// Loadable down-counter that holds each pattern for SETTLE_CYCLES cycles.
module nand8_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic zero_o
);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on strobe, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nand8_test_sequencer.sv
// Sweeps all 256 patterns through an 8-input NAND, samples after a settle window
// and accumulates a pass/fail summary.
// Optional: NAND8_SEQ_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module nand8_test_sequencer
    import nand8_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    nand8_test_sequencer_if.slave        bus
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_SAMPLE = SAMPLE;
    localparam logic [1:0] S_DONE   = DONE;

    logic [1:0]        state_q,  state_d;
    logic [PAT_W-1:0]  dut_in_q, dut_in_d;
    logic [ERR_W-1:0]  err_q,    err_d;
    logic [PAT_W-1:0]  ff_q,     ff_d;
    logic              ffv_q,    ffv_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              load;
    logic              zero;
    logic              mismatch;

    nand8_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .zero_o (zero)
    );

    // Next-state, pattern stepping and result accumulation.
    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        load     = 1'b0;
        mismatch = (state_q == S_SAMPLE) && (bus.dut_y != nand8_expected(dut_in_q));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_SETTLE;
                    dut_in_d = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                    load     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (zero) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ff_d  = dut_in_q;
                        ffv_d = 1'b1;
                    end
                end
`ifdef NAND8_SEQ_STOP_ON_FAIL_EN
                if (mismatch || (dut_in_q == LAST_PAT)) begin
                    state_d = S_DONE;
                end else begin
                    dut_in_d = dut_in_q + PAT_W'(1);
                    load     = 1'b1;
                    state_d  = S_SETTLE;
                end
`else
                if (dut_in_q == LAST_PAT) begin
                    state_d = S_DONE;
                end else begin
                    dut_in_d = dut_in_q + PAT_W'(1);
                    load     = 1'b1;
                    state_d  = S_SETTLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.dut_in           = dut_in_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail       = ff_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.pass             = done_q && (err_q == '0);

endmodule

// File: tb/tb_nand8_test_sequencer.sv
// Scoreboard bench for nand8_test_sequencer against a delayed NAND gate model with faults.
module tb_nand8_test_sequencer;
    import nand8_seq_pkg::*;

    typedef struct {
        int unsigned err;
        int unsigned ff;
        int unsigned ffv;
        int unsigned pass;
        int unsigned din;
        int unsigned lat;
    } exp_t;

    logic clk;
    logic reset;
    int   fault;      // 0 good, 1 y stuck-1, 2 y stuck-0, 3 input c stuck-0
    int   cyc;
    int   start_edge;
    int   n_cmp;
    int   n_err;
    logic done_prev;
    exp_t sb_q[$];

    nand8_test_sequencer_if tb_if ();

    nand8_test_sequencer #(
        .SETTLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_if)
    );

    function automatic logic gate_model(input logic [7:0] p, input int m);
        logic [7:0] q;
        q = p;
        if (m == 3) q[5] = 1'b0;
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (q != 8'hFF);
        endcase
    endfunction

    assign #10 tb_if.dut_y = gate_model(tb_if.dut_in, fault);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on each rising done, pop the expected sweep result and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (tb_if.done && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("latency",          cyc - start_edge,              e.lat);
                chk("err_count",        tb_if.err_count,               e.err);
                chk("first_fail",       tb_if.first_fail,              e.ff);
                chk("first_fail_valid", tb_if.first_fail_valid,        e.ffv);
                chk("pass",             tb_if.pass,                    e.pass);
                chk("dut_in_at_done",   tb_if.dut_in,                  e.din);
                chk("busy_at_done",     tb_if.busy,                    0);
            end
        end
        done_prev = tb_if.done;
    end

    task automatic wait_done();
        int k = 0;
        while (!tb_if.done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!tb_if.done) chk("done_timeout", 0, 1);
    endtask

    task automatic launch(input int m, input bit hold);
        @(negedge clk);
        fault = m;
        tb_if.start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        chk("busy_after_start", tb_if.busy, 1);
        chk("done_after_start", tb_if.done, 0);
        chk("dut_in_first",     tb_if.dut_in, 0);
        if (!hold) tb_if.start = 1'b0;
    endtask

    task automatic sweep(input int m, input exp_t e);
        sb_q.push_back(e);
        launch(m, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("done_holds",   tb_if.done,      1);
        chk("dut_in_holds", tb_if.dut_in,    e.din);
        chk("err_holds",    tb_if.err_count, e.err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut_in"}, tb_if.dut_in,           0);
        chk({tag, "_busy"},   tb_if.busy,             0);
        chk({tag, "_done"},   tb_if.done,             0);
        chk({tag, "_pass"},   tb_if.pass,             0);
        chk({tag, "_err"},    tb_if.err_count,        0);
        chk({tag, "_ff"},     tb_if.first_fail,       0);
        chk({tag, "_ffv"},    tb_if.first_fail_valid, 0);
    endtask

    initial begin
        exp_t e_good, e_st1, e_st0, e_c0;
        cyc = 0; n_cmp = 0; n_err = 0; fault = 0;
        done_prev = 1'b0; start_edge = 0;
        reset = 1'b1;
        tb_if.start = 1'b0;

        e_good = '{err: 0,   ff: 0,     ffv: 0, pass: 1, din: 8'hFF, lat: 1280};
        e_st1  = '{err: 1,   ff: 8'hFF, ffv: 1, pass: 0, din: 8'hFF, lat: 1280};
`ifdef NAND8_SEQ_STOP_ON_FAIL_EN
        e_st0  = '{err: 1,   ff: 8'h00, ffv: 1, pass: 0, din: 8'h00, lat: 5};
`else
        e_st0  = '{err: 255, ff: 8'h00, ffv: 1, pass: 0, din: 8'hFF, lat: 1280};
`endif
        e_c0   = '{err: 1,   ff: 8'hFF, ffv: 1, pass: 0, din: 8'hFF, lat: 1280};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", tb_if.busy, 0);

        sweep(0, e_good);
        sweep(1, e_st1);
        sweep(2, e_st0);
        sweep(3, e_c0);

        // Abort mid-sweep with reset, then run a full clean sweep.
        launch(0, 1'b0);
        repeat (598) @(negedge clk);
        chk("midsweep_busy", tb_if.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("abort");
        @(negedge clk);
        chk("abort_stays_idle", tb_if.busy, 0);
        sweep(0, e_good);

        // start held high: no mid-sweep restart, immediate restart from DONE.
        sb_q.push_back(e_st1);
        launch(1, 1'b1);
        wait_done();
        @(negedge clk);
        chk("restart_done_low", tb_if.done,             0);
        chk("restart_busy",     tb_if.busy,             1);
        chk("restart_err_clr",  tb_if.err_count,        0);
        chk("restart_ffv_clr",  tb_if.first_fail_valid, 0);
        chk("restart_dut_in",   tb_if.dut_in,           0);
        tb_if.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
